// File: rtl/timebase_cascade.sv
// -----------------------------------------------------------------------------
// timebase_cascade
//
// Cascaded, run-time programmable timebase in a single clock domain. It
// replaces a chain of independent clock dividers. Stage 0 advances on every
// enabled Clk cycle. Stage k advances on the cycle in which stage k-1 wraps.
// Every stage produces:
//   * a one-cycle Tick strobe on its wrap;
//   * a duty-cycle Level, high while the stage count is below its high-count.
//
// Each stage has two copies of its divisor and high-count:
//   * a shadow copy, written through the Cfg* port;
//   * an active copy, used for counting.
// The active copy reloads from the shadow only when its counter returns to 0,
// either on a wrap or on SyncClear. A reprogrammed period therefore never
// starts part-way through.
//
// Parameters
//   STAGES       number of cascaded stages (>= 1)
//   CNT_WIDTH    width of every counter / divisor / high-count
//   DIVISORS     packed reset divisors, stage 0 in the LSBs (0 is taken as 1)
//   HIGH_COUNTS  packed reset high-counts, same packing
//
// Ports
//   Clk           sole clock
//   Rst_n         asynchronous active-low reset
//   Enable        advances stage 0 when high
//   SyncClear     zero all counters and load shadows into the active registers
//   CfgWe         shadow configuration write strobe
//   CfgStage      target stage of the write (out-of-range values are ignored)
//   CfgDivisor    new divisor (0 is stored as 1)
//   CfgHighCount  new high-count
//   Tick          registered wrap strobe, one bit per stage
//   Level         registered duty-cycle level, one bit per stage
//   Count         registered counter values, packed like DIVISORS
// -----------------------------------------------------------------------------
module timebase_cascade #(
    parameter int STAGES    = 3,
    parameter int CNT_WIDTH = 28,
    parameter logic [STAGES*CNT_WIDTH-1:0] DIVISORS    = {28'd1000, 28'd1000, 28'd50},
    parameter logic [STAGES*CNT_WIDTH-1:0] HIGH_COUNTS = {28'd500, 28'd800, 28'd25},
    localparam int SEL_WIDTH = (STAGES > 1) ? $clog2(STAGES) : 1
) (
    input  logic                        Clk,
    input  logic                        Rst_n,
    input  logic                        Enable,
    input  logic                        SyncClear,
    input  logic                        CfgWe,
    input  logic [SEL_WIDTH-1:0]        CfgStage,
    input  logic [CNT_WIDTH-1:0]        CfgDivisor,
    input  logic [CNT_WIDTH-1:0]        CfgHighCount,
    output logic [STAGES-1:0]           Tick,
    output logic [STAGES-1:0]           Level,
    output logic [STAGES*CNT_WIDTH-1:0] Count
);

    localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

    logic                 cfg_valid;
    logic [CNT_WIDTH-1:0] cfg_div_eff;
    logic [STAGES-1:0]    at_last;   // stage count sits at div-1
    logic [STAGES-1:0]    adv;       // stage advances this cycle
    logic [STAGES-1:0]    wrap;      // stage wraps this cycle

    assign cfg_valid   = CfgWe && (int'(CfgStage) < STAGES);
    assign cfg_div_eff = (CfgDivisor == '0) ? ONE : CfgDivisor;

    // The carry chain is resolved in one block so that every stage that wraps
    // on a given edge does so on that same edge. Nested ticks then coincide.
    always_comb begin
        adv     = '0;
        wrap    = '0;
        adv[0]  = Enable & ~SyncClear;
        wrap[0] = adv[0] & at_last[0];
        for (int k = 1; k < STAGES; k++) begin
            adv[k]  = wrap[k-1];
            wrap[k] = adv[k] & at_last[k];
        end
    end

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        localparam logic [CNT_WIDTH-1:0] RST_DIV_RAW = DIVISORS[gi*CNT_WIDTH +: CNT_WIDTH];
        localparam logic [CNT_WIDTH-1:0] RST_DIV     = (RST_DIV_RAW == '0) ? ONE : RST_DIV_RAW;
        localparam logic [CNT_WIDTH-1:0] RST_HIGH    = HIGH_COUNTS[gi*CNT_WIDTH +: CNT_WIDTH];

        logic [CNT_WIDTH-1:0] cnt_reg,     cnt_next;
        logic [CNT_WIDTH-1:0] div_reg,     div_next;
        logic [CNT_WIDTH-1:0] high_reg,    high_next;
        logic [CNT_WIDTH-1:0] div_sh_reg,  div_sh_next;
        logic [CNT_WIDTH-1:0] high_sh_reg, high_sh_next;
        logic                 tick_reg;
        logic                 level_reg,   level_next;
        logic                 cfg_hit;
        logic                 load;

        assign cfg_hit = cfg_valid && (int'(CfgStage) == gi);

        // The active registers only reload when the counter is about to be 0.
        // A shrinking divisor therefore can never leave cnt beyond div-1.
        assign load = wrap[gi] | SyncClear;

        // div_reg is never 0, so div_reg-1 does not underflow.
        assign at_last[gi] = (cnt_reg == div_reg - ONE);

        always_comb begin
            cnt_next = cnt_reg;
            if (SyncClear || wrap[gi]) begin
                cnt_next = '0;
            end else if (adv[gi]) begin
                cnt_next = cnt_reg + ONE;
            end
        end

        always_comb begin
            div_sh_next  = div_sh_reg;
            high_sh_next = high_sh_reg;
            if (cfg_hit) begin
                div_sh_next  = cfg_div_eff;
                high_sh_next = CfgHighCount;
            end
        end

        // A write that lands on the same edge as a load bypasses the shadow.
        // The new period then uses it immediately.
        always_comb begin
            div_next  = div_reg;
            high_next = high_reg;
            if (load) begin
                div_next  = div_sh_next;
                high_next = high_sh_next;
            end
        end

        // Compare against the high-count that applies to the count being
        // registered. Level then stays aligned with Count across a reload.
        assign level_next = (cnt_next < high_next);

        always_ff @(posedge Clk or negedge Rst_n) begin
            if (!Rst_n) begin
                cnt_reg     <= '0;
                div_reg     <= RST_DIV;
                high_reg    <= RST_HIGH;
                div_sh_reg  <= RST_DIV;
                high_sh_reg <= RST_HIGH;
                tick_reg    <= 1'b0;
                level_reg   <= 1'b0;
            end else begin
                cnt_reg     <= cnt_next;
                div_reg     <= div_next;
                high_reg    <= high_next;
                div_sh_reg  <= div_sh_next;
                high_sh_reg <= high_sh_next;
                tick_reg    <= wrap[gi];
                level_reg   <= level_next;
            end
        end

        assign Tick[gi]                           = tick_reg;
        assign Level[gi]                          = level_reg;
        assign Count[gi*CNT_WIDTH +: CNT_WIDTH]   = cnt_reg;
    end

endmodule

// File: tb/tb_timebase_cascade.sv
// -----------------------------------------------------------------------------
// Scoreboard bench for timebase_cascade.
// Configuration: 3 stages, 8-bit counters.
//   Divisors    (stage 2,1,0) = 3,4,5
//   High-counts (stage 2,1,0) = 1,2,2
// The stimulus process issues one cycle at a time. For each cycle it pushes
// the expected Tick, Level and Count for the edge that follows. The expected
// values come from the closed-form cascade arithmetic:
//   c1 = w0 mod 4, c2 = (w0 div 4) mod 3,
// where w0 is the number of stage-0 wraps since the counters were last
// zeroed. The monitor pops and compares on every falling edge.
// -----------------------------------------------------------------------------
module tb_timebase_cascade;

    localparam int STAGES = 3;
    localparam int W      = 8;

    logic                 Clk = 1'b0;
    logic                 Rst_n;
    logic                 Enable;
    logic                 SyncClear;
    logic                 CfgWe;
    logic [1:0]           CfgStage;
    logic [W-1:0]         CfgDivisor;
    logic [W-1:0]         CfgHighCount;
    logic [STAGES-1:0]    Tick;
    logic [STAGES-1:0]    Level;
    logic [STAGES*W-1:0]  Count;

    timebase_cascade #(
        .STAGES      (STAGES),
        .CNT_WIDTH   (W),
        .DIVISORS    ({8'd3, 8'd4, 8'd5}),
        .HIGH_COUNTS ({8'd1, 8'd2, 8'd2})
    ) dut (
        .Clk          (Clk),
        .Rst_n        (Rst_n),
        .Enable       (Enable),
        .SyncClear    (SyncClear),
        .CfgWe        (CfgWe),
        .CfgStage     (CfgStage),
        .CfgDivisor   (CfgDivisor),
        .CfgHighCount (CfgHighCount),
        .Tick         (Tick),
        .Level        (Level),
        .Count        (Count)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int          cyc;
        int          field;   // 0 Tick, 1 Level, 2 Count
        logic [23:0] val;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [23:0] act, input logic [23:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h, want %h", nm, cyc, act, exp);
        end
    endtask

    task automatic push(input int f, input logic [23:0] v, input string nm);
        exp_t e;
        e.cyc   = cyc + 1;
        e.field = f;
        e.val   = v;
        e.name  = nm;
        sb.push_back(e);
    endtask

    // Queue the expected outputs for the next edge, then advance one cycle.
    task automatic exp_raw(input logic [2:0] tk, input logic [2:0] lv,
                           input logic [23:0] cnt, input string tag);
        push(0, {21'b0, tk}, {tag, ".tick"});
        push(1, {21'b0, lv}, {tag, ".level"});
        push(2, cnt,         {tag, ".count"});
        $display("cyc %0d %s: expect tick=%b level=%b count=%h", cyc + 1, tag, tk, lv, cnt);
        @(negedge Clk);
    endtask

    // c0: stage-0 count after the edge
    // w0: total stage-0 wraps since counters were last zeroed
    // t0: stage 0 wraps on this edge
    // h0: stage-0 high-count in force after the edge
    task automatic exp_state(input int c0, input int w0, input bit t0, input int h0,
                             input string tag);
        int         c1;
        int         c2;
        logic       t1;
        logic       t2;
        logic [2:0] lv;
        c1 = w0 % 4;
        c2 = (w0 / 4) % 3;
        t1 = t0 && (c1 == 0);
        t2 = t1 && (c2 == 0);
        lv = {c2 < 1, c1 < 2, c0 < h0};
        exp_raw({t2, t1, t0}, lv, {8'(c2), 8'(c1), 8'(c0)}, tag);
    endtask

    task automatic set_cfg(input logic [1:0] st, input int d, input int h);
        CfgWe        = 1'b1;
        CfgStage     = st;
        CfgDivisor   = 8'(d);
        CfgHighCount = 8'(h);
    endtask

    // Monitor: compare every record whose cycle has arrived.
    initial begin
        exp_t        e;
        logic [23:0] act;
        forever begin
            @(negedge Clk);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                case (e.field)
                    0:       act = {21'b0, Tick};
                    1:       act = {21'b0, Level};
                    default: act = Count;
                endcase
                if (e.cyc != cyc) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL %s: slot %0d missed at cyc %0d", e.name, e.cyc, cyc);
                end else begin
                    check(e.name, act, e.val);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        Rst_n        = 1'b0;
        Enable       = 1'b0;
        SyncClear    = 1'b0;
        CfgWe        = 1'b0;
        CfgStage     = 2'd0;
        CfgDivisor   = '0;
        CfgHighCount = '0;
        @(negedge Clk);

        // Held in reset: everything zero.
        exp_raw(3'b000, 3'b000, 24'h0, "reset");
        exp_raw(3'b000, 3'b000, 24'h0, "reset");

        // Free run from reset: periods 5 / 20 / 60, nested ticks coincide.
        Rst_n  = 1'b1;
        Enable = 1'b1;
        for (int a = 1; a <= 60; a++) exp_state(a % 5, a / 5, (a % 5) == 0, 2, "run");

        // high-count 0: Level[0] constant 0.
        SyncClear = 1'b1;
        set_cfg(2'd0, 5, 0);
        exp_state(0, 0, 1'b0, 0, "clr_h0");
        SyncClear = 1'b0;
        CfgWe     = 1'b0;
        for (int a = 1; a <= 10; a++) exp_state(a % 5, a / 5, (a % 5) == 0, 0, "h0");

        // high-count 7 >= divisor: Level[0] constant 1.
        SyncClear = 1'b1;
        set_cfg(2'd0, 5, 7);
        exp_state(0, 0, 1'b0, 7, "clr_h7");
        SyncClear = 1'b0;
        CfgWe     = 1'b0;
        for (int a = 1; a <= 10; a++) exp_state(a % 5, a / 5, (a % 5) == 0, 7, "h7");

        // Enable low for 7 cycles mid-period: everything freezes, then resumes.
        SyncClear = 1'b1;
        set_cfg(2'd0, 5, 2);
        exp_state(0, 0, 1'b0, 2, "clr_h2");
        SyncClear = 1'b0;
        CfgWe     = 1'b0;
        for (int a = 1; a <= 7; a++) exp_state(a % 5, a / 5, (a % 5) == 0, 2, "pre_hold");
        Enable = 1'b0;
        for (int i = 0; i < 7; i++) exp_state(2, 1, 1'b0, 2, "hold");
        Enable = 1'b1;
        for (int a = 8; a <= 15; a++) exp_state(a % 5, a / 5, (a % 5) == 0, 2, "resume");

        // Reprogram stage 0 to div 8 / high 3 while its count is 2: the
        // running period still ends at 5, later periods are 8.
        SyncClear = 1'b1;
        exp_state(0, 0, 1'b0, 2, "clr");
        SyncClear = 1'b0;
        for (int a = 1; a <= 5; a++) begin
            if (a == 3) set_cfg(2'd0, 8, 3);
            exp_state(a % 5, a / 5, (a % 5) == 0, (a == 5) ? 3 : 2, "reprog");
            CfgWe = 1'b0;
        end
        // Write on the wrap edge at a=29 takes effect immediately (div 5).
        for (int a = 6; a <= 29; a++) begin
            if (a == 29) set_cfg(2'd0, 5, 2);
            exp_state((a - 5) % 8, 1 + (a - 5) / 8, ((a - 5) % 8) == 0,
                      (a == 29) ? 2 : 3, "div8");
            CfgWe = 1'b0;
        end
        for (int a = 30; a <= 42; a++)
            exp_state((a - 29) % 5, 4 + (a - 29) / 5, ((a - 29) % 5) == 0, 2, "wrap_wr");

        // SyncClear mid-count with a write to invalid stage 3: counts zero,
        // configuration unchanged, next Tick[0] five cycles later.
        SyncClear = 1'b1;
        set_cfg(2'd3, 2, 1);
        exp_state(0, 0, 1'b0, 2, "clr_bad");
        SyncClear = 1'b0;
        CfgWe     = 1'b0;
        for (int a = 1; a <= 11; a++) exp_state(a % 5, a / 5, (a % 5) == 0, 2, "after_bad");

        // Pending shadow write (div 7 / high 6), then an async reset pulse
        // between edges: outputs drop at once and the parameters return.
        set_cfg(2'd0, 7, 6);
        exp_state(2, 2, 1'b0, 2, "pending");
        CfgWe = 1'b0;
        exp_state(3, 2, 1'b0, 2, "pending");
        #1 Rst_n = 1'b0;
        #1;
        check("async_rst.tick",  {21'b0, Tick},  24'h0);
        check("async_rst.level", {21'b0, Level}, 24'h0);
        check("async_rst.count", Count,          24'h0);
        #2 Rst_n = 1'b1;
        for (int a = 1; a <= 12; a++) exp_state(a % 5, a / 5, (a % 5) == 0, 2, "post_rst");

        repeat (3) @(negedge Clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d records left, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
